// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 main control FSM: sequences fetch/decode/execute/memory/writeback and drives AluOp plus datapath strobes.
// Optional `ILLEGAL_TRAP_EN` adds an Illegal output and a sticky TRAP state for unmatched opcodes.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        Zero,
    input  logic        InstrReady,
    input  logic        MemReady,
    output logic [1:0]  AluOp,
    output logic        Reg2Loc,
    output logic        AluSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Uncond,
    output logic        PcWrite,
    output logic        IrWrite,
    output logic        MemTimeout
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        Illegal
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_ADDR,
        S_MEM_RD,
        S_WB_LD,
        S_MEM_WR,
        S_CBZ,
        S_BR
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic is_rtype;
    logic is_mem;
    logic is_cbz;
    logic is_b;
    logic mem_state;
    logic timeout_hit;

    always_comb begin
        is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_ORR);
        is_mem   = (opcode == OP_LDUR) || (opcode == OP_STUR);
        is_cbz   = (opcode[10:3] == 8'b10110100);
        is_b     = (opcode[10:5] == 6'b000101);
    end

    // MemReady has priority: the abort only fires on the last allowed cycle with no completion.
    assign mem_state   = (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout_hit = mem_state && !MemReady && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (InstrReady) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_rtype)    state <= S_EXEC_R;
                    else if (is_mem) state <= S_ADDR;
                    else if (is_cbz) state <= S_CBZ;
                    else if (is_b)   state <= S_BR;
`ifdef ILLEGAL_TRAP_EN
                    else             state <= S_TRAP;
`else
                    else             state <= S_FETCH;
`endif
                end
                S_EXEC_R: state <= S_WB_R;
                S_WB_R:   state <= S_FETCH;
                S_ADDR: begin
                    state    <= (opcode == OP_LDUR) ? S_MEM_RD : S_MEM_WR;
                    wait_cnt <= '0;
                end
                S_MEM_RD, S_MEM_WR: begin
                    if (MemReady) begin
                        state    <= (state == S_MEM_RD) ? S_WB_LD : S_FETCH;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end else if (wait_cnt != CNT_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB_LD: state <= S_FETCH;
                S_CBZ:   state <= S_FETCH;
                S_BR:    state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:  state <= S_TRAP;
`endif
                default: state <= S_FETCH;
            endcase
        end
    end

    // Gating on reset keeps every strobe low while reset is held, including the InstrReady-driven ones.
    always_comb begin
        AluOp      = 2'b00;
        Reg2Loc    = 1'b0;
        AluSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        Uncond     = 1'b0;
        PcWrite    = 1'b0;
        IrWrite    = 1'b0;
        MemTimeout = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        Illegal    = 1'b0;
`endif
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    IrWrite = InstrReady;
                    PcWrite = InstrReady;
                end
                S_EXEC_R: AluOp = 2'b10;
                S_WB_R: begin
                    AluOp    = 2'b10;
                    RegWrite = 1'b1;
                end
                S_ADDR: AluSrc = 1'b1;
                S_MEM_RD: begin
                    AluSrc     = 1'b1;
                    MemRead    = 1'b1;
                    MemTimeout = timeout_hit;
                end
                S_MEM_WR: begin
                    AluSrc     = 1'b1;
                    Reg2Loc    = 1'b1;
                    MemWrite   = 1'b1;
                    MemTimeout = timeout_hit;
                end
                S_WB_LD: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    AluSrc   = 1'b1;
                end
                S_CBZ: begin
                    AluOp   = 2'b01;
                    Reg2Loc = 1'b1;
                    Branch  = 1'b1;
                    PcWrite = Zero;
                end
                S_BR: begin
                    Uncond  = 1'b1;
                    PcWrite = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: Illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected strobe sequences are built from the instruction class.
module tb_multicycle_control;

    localparam int MT = 4;

    localparam int K_R   = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_CBZ = 3;
    localparam int K_B   = 4;
    localparam int K_NOP = 5;

    localparam logic [13:0] ILL  = 14'h2000;
    localparam logic [13:0] ALUR = 14'h1000;
    localparam logic [13:0] ALUP = 14'h0800;
    localparam logic [13:0] R2L  = 14'h0400;
    localparam logic [13:0] ASRC = 14'h0200;
    localparam logic [13:0] M2R  = 14'h0100;
    localparam logic [13:0] RW   = 14'h0080;
    localparam logic [13:0] MRD  = 14'h0040;
    localparam logic [13:0] MWR  = 14'h0020;
    localparam logic [13:0] BRN  = 14'h0010;
    localparam logic [13:0] UNC  = 14'h0008;
    localparam logic [13:0] PCW  = 14'h0004;
    localparam logic [13:0] IRW  = 14'h0002;
    localparam logic [13:0] MTO  = 14'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        Zero, InstrReady, MemReady;
    logic [1:0]  AluOp;
    logic        Reg2Loc, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic        Branch, Uncond, PcWrite, IrWrite, MemTimeout;
    logic        ill_obs;
    logic [13:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    bit          q_ir[$];
    bit          q_mr[$];
    bit          q_z[$];
    logic [13:0] q_exp[$];
    string       q_tag[$];

    multicycle_control #(.MEM_TIMEOUT(MT), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero),
        .InstrReady(InstrReady), .MemReady(MemReady), .AluOp(AluOp),
        .Reg2Loc(Reg2Loc), .AluSrc(AluSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .Uncond(Uncond), .PcWrite(PcWrite),
        .IrWrite(IrWrite), .MemTimeout(MemTimeout)
`ifdef ILLEGAL_TRAP_EN
        , .Illegal(ill_obs)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign ill_obs = 1'b0;
`endif

    assign obs = {ill_obs, AluOp, Reg2Loc, AluSrc, MemtoReg, RegWrite, MemRead,
                  MemWrite, Branch, Uncond, PcWrite, IrWrite, MemTimeout};

    always #5 clk = ~clk;

    function automatic int classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return K_R;
        if (op == 11'b11111000010) return K_LD;
        if (op == 11'b11111000000) return K_ST;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:5] == 6'b000101) return K_B;
        return K_NOP;
    endfunction

    function automatic logic [10:0] make_op(input int k);
        logic [10:0] op;
        case (k)
            K_R: begin
                case ($urandom_range(0, 3))
                    0:       op = 11'b10001011000;
                    1:       op = 11'b11001011000;
                    2:       op = 11'b10001010000;
                    default: op = 11'b10101010000;
                endcase
            end
            K_LD:  op = 11'b11111000010;
            K_ST:  op = 11'b11111000000;
            K_CBZ: op = {8'b10110100, 3'($urandom)};
            K_B:   op = {6'b000101, 5'($urandom)};
            default: begin
                op = 11'($urandom);
                while (classify(op) != K_NOP) op = 11'($urandom);
            end
        endcase
        return op;
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic check(input logic [13:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [10:0] op, input bit ir, input bit mr, input bit z,
                        input logic [13:0] exp, input string tag);
        @(negedge clk);
        opcode     = op;
        InstrReady = ir;
        MemReady   = mr;
        Zero       = z;
        #2;
        check(exp, tag);
    endtask

    task automatic push(input bit ir, input bit mr, input bit z, input logic [13:0] e, input string t);
        q_ir.push_back(ir);
        q_mr.push_back(mr);
        q_z.push_back(z);
        q_exp.push_back(e);
        q_tag.push_back(t);
    endtask

    // ready_at: memory cycle (1-based) on which MemReady rises; > MT means never. Negative means random.
    task automatic run_instr(input int k, input int ready_at, input int zero);
        logic [10:0] op;
        int          ra, n;
        bit          z;
        logic [13:0] base;
        op = make_op(k);
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) push(1'b0, rb(), rb(), 14'h0, "fetch_wait");
        push(1'b1, rb(), rb(), IRW | PCW, "fetch");
        push(rb(), rb(), rb(), 14'h0, "decode");
        case (k)
            K_R: begin
                push(rb(), rb(), rb(), ALUR, "exec_r");
                push(rb(), rb(), rb(), ALUR | RW, "wb_r");
            end
            K_LD, K_ST: begin
                push(rb(), rb(), rb(), ASRC, "addr");
                ra   = (ready_at < 0) ? int'($urandom_range(1, MT + 1)) : ready_at;
                n    = (ra > MT) ? MT : ra;
                base = (k == K_LD) ? (ASRC | MRD) : (ASRC | R2L | MWR);
                for (int i = 1; i <= n; i++)
                    push(rb(), (i == ra), rb(), base | ((i == MT && ra > MT) ? MTO : 14'h0),
                         (k == K_LD) ? "mem_rd" : "mem_wr");
                if (k == K_LD && ra <= MT) push(rb(), rb(), rb(), RW | M2R | ASRC, "wb_ld");
            end
            K_CBZ: begin
                z = (zero < 0) ? rb() : (zero != 0);
                push(rb(), rb(), z, ALUP | R2L | BRN | (z ? PCW : 14'h0), "cbz");
            end
            K_B: push(rb(), rb(), rb(), UNC | PCW, "br");
            default: ;
        endcase
        while (q_exp.size() > 0)
            step(op, q_ir.pop_front(), q_mr.pop_front(), q_z.pop_front(), q_exp.pop_front(), q_tag.pop_front());
    endtask

    task automatic reset_mid_load();
        logic [10:0] op;
        op = 11'b11111000010;
        step(op, 1'b1, 1'b0, 1'b0, IRW | PCW, "rst_fetch");
        step(op, 1'b0, 1'b0, 1'b0, 14'h0, "rst_decode");
        step(op, 1'b0, 1'b0, 1'b0, ASRC, "rst_addr");
        step(op, 1'b0, 1'b0, 1'b0, ASRC | MRD, "rst_mrd1");
        step(op, 1'b0, 1'b0, 1'b0, ASRC | MRD, "rst_mrd2");
        #1 reset = 1'b1;
        #1 check(14'h0, "rst_async_drop");
        step(op, 1'b1, 1'b1, 1'b1, 14'h0, "rst_hold");
        @(negedge clk);
        InstrReady = 1'b0;
        reset      = 1'b0;
    endtask

`ifdef ILLEGAL_TRAP_EN
    task automatic run_trap();
        logic [10:0] op;
        op = make_op(K_NOP);
        step(op, 1'b1, rb(), rb(), IRW | PCW, "trap_fetch");
        step(op, rb(), rb(), rb(), 14'h0, "trap_decode");
        for (int i = 0; i < 12; i++) step(op, rb(), rb(), rb(), ILL, "trap_hold");
        @(negedge clk);
        reset = 1'b1;
        #2 check(14'h0, "trap_reset");
        @(negedge clk);
        InstrReady = 1'b0;
        reset      = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        opcode     = '0;
        Zero       = 1'b0;
        InstrReady = 1'b0;
        MemReady   = 1'b0;
        #1 check(14'h0, "reset_state");
        for (int i = 0; i < 3; i++) step(11'b11111000010, 1'b1, 1'b1, 1'b1, 14'h0, "reset_hold");
        @(negedge clk);
        InstrReady = 1'b0;
        reset      = 1'b0;

        run_instr(K_R, -1, -1);
        run_instr(K_LD, 3, -1);
        run_instr(K_ST, MT + 1, -1);
        run_instr(K_ST, MT, -1);
        run_instr(K_LD, MT + 1, -1);
        run_instr(K_CBZ, -1, 1);
        run_instr(K_CBZ, -1, 0);
        run_instr(K_B, -1, -1);
`ifdef ILLEGAL_TRAP_EN
        run_trap();
`else
        run_instr(K_NOP, -1, -1);
`endif
        reset_mid_load();
        run_instr(K_ST, MT + 1, -1);
        run_instr(K_LD, MT, -1);

        for (int i = 0; i < 200; i++) begin
`ifdef ILLEGAL_TRAP_EN
            run_instr(int'($urandom_range(0, 4)), -1, -1);
`else
            run_instr(int'($urandom_range(0, 5)), -1, -1);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
